// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and the round-robin search helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);
    localparam int unsigned BCNT_W    = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_res_t;

    // First set bit of req_mask scanning upward from start, wrapping at n.
    function automatic rr_res_t rr_next(input logic [N_REQ_MAX-1:0] req_mask,
                                        input logic [IDX_W-1:0]     start,
                                        input int unsigned          n);
        rr_res_t     res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < N_REQ_MAX; k++) begin
            pos = 32'(start) + k;
            if (pos >= n) pos = pos - n;
            if (k < n && !res.valid && req_mask[IDX_W'(pos)]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(pos);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker: first eligible requester at or after start.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int unsigned IW = $clog2(N);

    rr_res_t w_pick;

    always_comb begin
        w_pick = rr_next(N_REQ_MAX'(req & mask), IDX_W'(start), N);
    end

    assign valid  = w_pick.valid;
    assign idx    = IW'(w_pick.idx);
    assign onehot = w_pick.valid ? N'(N_REQ_MAX'(1) << w_pick.idx) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one FIFO write port;
// never issues a write that could overflow and flags wr_ack/overflow errors.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(N_REQ)-1:0]      owner,
    output logic                          ack_err,
    output logic                          ovf_err,
    input  logic                          err_clr
);

    localparam int unsigned IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX || MAX_BURST < 1 ||
        MAX_BURST >= (1 << BCNT_W) || FIFO_DEPTH < 2) begin : g_cfg_err
        $error("fifo_wr_arbiter: unsupported parameter set");
    end

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [BCNT_W-1:0]       r_burst_cnt;
    logic [BCNT_W-1:0]       w_burst_nxt;
    logic [IW-1:0]           r_owner;
    logic                    r_wr_en;
    logic [FIFO_WIDTH-1:0]   r_data;
    logic                    r_ack_exp;
    logic                    r_ack_err;
    logic                    r_ovf_err;

    logic                    w_space;
    logic                    w_allow;
    logic [IW-1:0]           w_start;
    logic [N_REQ-1:0]        w_pick_onehot;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_pick_valid;
    logic [N_REQ-1:0]        w_owner_onehot;
    logic                    w_cont;
    logic                    w_xfer;
    logic [IW-1:0]           w_gnt_idx;

    // A write already in flight at almostfull would fill the FIFO, so hold off.
    assign w_space        = !fifo_full && !(fifo_almostfull && r_wr_en);
    assign w_allow        = rst_n && arb_en && w_space;
    assign w_start        = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);
    assign w_owner_onehot = N_REQ'(1) << r_owner;

    // Scanning from owner+1 visits the current owner last, so it only wins when alone.
    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .mask   ({N_REQ{w_allow}}),
        .start  (w_start),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Next state: continuing a burst counts up, any fresh pick restarts at one.
    always_comb begin
        w_state_nxt = ARB;
        w_burst_nxt = '0;
        if (w_cont) begin
            w_state_nxt = BURST;
            w_burst_nxt = r_burst_cnt + BCNT_W'(1);
        end else if (w_xfer) begin
            w_state_nxt = BURST;
            w_burst_nxt = BCNT_W'(1);
        end
    end

    // Grant decode
    always_comb begin
        w_cont    = 1'b0;
        w_xfer    = 1'b0;
        gnt       = '0;
        w_gnt_idx = r_owner;
        if (w_allow && r_state == BURST && req[r_owner] &&
            r_burst_cnt < BCNT_W'(MAX_BURST)) begin
            w_cont = 1'b1;
            w_xfer = 1'b1;
            gnt    = w_owner_onehot;
        end else if (w_pick_valid) begin
            w_xfer    = 1'b1;
            gnt       = w_pick_onehot;
            w_gnt_idx = w_pick_idx;
        end
    end

    // Registered FIFO write port and owner tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en <= 1'b0;
            r_data  <= '0;
            r_owner <= IW'(N_REQ - 1);
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_data  <= req_data[w_gnt_idx*FIFO_WIDTH +: FIFO_WIDTH];
                r_owner <= w_gnt_idx;
            end
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_exp <= 1'b0;
            r_ack_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_ack_exp <= r_wr_en;
            if (fifo_wr_ack != r_ack_exp) r_ack_err <= 1'b1;
            else if (err_clr)             r_ack_err <= 1'b0;
            if (fifo_overflow)            r_ovf_err <= 1'b1;
            else if (err_clr)             r_ovf_err <= 1'b0;
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_data_in = r_data;
    assign owner        = r_owner;
    assign ack_err      = r_ack_err;
    assign ovf_err      = r_ovf_err;

endmodule
